// File: rtl/axil_cmd_mgr.sv
// axil_cmd_mgr: single-outstanding AXI-Lite manager. Accepts one register
// command, runs it as an AXI-Lite write (AW+W then B) or read (AR then R),
// and returns data, response code and the number of active cycles spent.
// All outputs come straight from registers.
module axil_cmd_mgr #(
  parameter int unsigned AXIL_ADDR_WIDTH = 32,
  parameter int unsigned AXIL_DATA_WIDTH = 32,  // 32 or 64
  parameter int unsigned LAT_CNT_WIDTH   = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  // command side
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic                         cmd_write_i,
  input  logic [AXIL_ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [AXIL_DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [AXIL_DATA_WIDTH/8-1:0] cmd_wstrb_i,
  // response side
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic                         rsp_write_o,
  output logic [AXIL_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]                   rsp_resp_o,
  output logic [LAT_CNT_WIDTH-1:0]     rsp_cycles_o,
  // AW channel
  output logic [AXIL_ADDR_WIDTH-1:0]   axil_aw_addr_o,
  output logic [2:0]                   axil_aw_prot_o,
  output logic                         axil_aw_valid_o,
  input  logic                         axil_aw_ready_i,
  // W channel
  output logic [AXIL_DATA_WIDTH-1:0]   axil_w_data_o,
  output logic [AXIL_DATA_WIDTH/8-1:0] axil_w_strb_o,
  output logic                         axil_w_valid_o,
  input  logic                         axil_w_ready_i,
  // B channel
  input  logic [1:0]                   axil_b_resp_i,
  input  logic                         axil_b_valid_i,
  output logic                         axil_b_ready_o,
  // AR channel
  output logic [AXIL_ADDR_WIDTH-1:0]   axil_ar_addr_o,
  output logic [2:0]                   axil_ar_prot_o,
  output logic                         axil_ar_valid_o,
  input  logic                         axil_ar_ready_i,
  // R channel
  input  logic [AXIL_DATA_WIDTH-1:0]   axil_r_data_i,
  input  logic [1:0]                   axil_r_resp_i,
  input  logic                         axil_r_valid_i,
  output logic                         axil_r_ready_o
);

  localparam int unsigned STRB_WIDTH = AXIL_DATA_WIDTH / 8;
  localparam logic [LAT_CNT_WIDTH-1:0] CNT_ONE = LAT_CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_B,
    S_RD_AR,
    S_RD_R,
    S_RSP
  } state_e;

  state_e                       state_q, state_d;
  logic                         wr_q, wr_d;
  logic [AXIL_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXIL_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]        wstrb_q, wstrb_d;
  logic                         aw_valid_q, aw_valid_d;
  logic                         w_valid_q, w_valid_d;
  logic                         b_ready_q, b_ready_d;
  logic                         ar_valid_q, ar_valid_d;
  logic                         r_ready_q, r_ready_d;
  logic                         cmd_ready_q, cmd_ready_d;
  logic                         rsp_valid_q, rsp_valid_d;
  logic [AXIL_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                   resp_q, resp_d;
  logic [LAT_CNT_WIDTH-1:0]     cnt_q, cnt_d;

  logic                         aw_pend, w_pend;

  // Each channel stays pending until its own handshake; the other may finish earlier.
  assign aw_pend = aw_valid_q & ~axil_aw_ready_i;
  assign w_pend  = w_valid_q  & ~axil_w_ready_i;

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    b_ready_d   = b_ready_q;
    ar_valid_d  = ar_valid_q;
    r_ready_d   = r_ready_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    cnt_d       = cnt_q;

    // Latency counts every active cycle, including the B/R handshake cycle, and saturates.
    if ((state_q == S_WR || state_q == S_WR_B || state_q == S_RD_AR || state_q == S_RD_R)
        && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid_i && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          wr_d        = cmd_write_i;
          addr_d      = cmd_addr_i;
          wdata_d     = cmd_wdata_i;
          wstrb_d     = cmd_wstrb_i;
          rdata_d     = '0;
          resp_d      = '0;
          cnt_d       = '0;
          if (cmd_write_i) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            state_d    = S_WR;
          end else begin
            ar_valid_d = 1'b1;
            state_d    = S_RD_AR;
          end
        end
      end
      S_WR: begin
        aw_valid_d = aw_pend;
        w_valid_d  = w_pend;
        if (!aw_pend && !w_pend) begin
          b_ready_d = 1'b1;
          state_d   = S_WR_B;
        end
      end
      S_WR_B: begin
        if (b_ready_q && axil_b_valid_i) begin
          b_ready_d   = 1'b0;
          resp_d      = axil_b_resp_i;
          rdata_d     = '0;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end
      S_RD_AR: begin
        if (axil_ar_ready_i) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = S_RD_R;
        end
      end
      S_RD_R: begin
        if (r_ready_q && axil_r_valid_i) begin
          r_ready_d   = 1'b0;
          rdata_d     = axil_r_data_i;
          resp_d      = axil_r_resp_i;
          rsp_valid_d = 1'b1;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      b_ready_q   <= b_ready_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready_o     = cmd_ready_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_write_o     = wr_q;
  assign rsp_rdata_o     = rdata_q;
  assign rsp_resp_o      = resp_q;
  assign rsp_cycles_o    = cnt_q;

  assign axil_aw_addr_o  = addr_q;
  assign axil_aw_prot_o  = 3'b000;
  assign axil_aw_valid_o = aw_valid_q;
  assign axil_w_data_o   = wdata_q;
  assign axil_w_strb_o   = wstrb_q;
  assign axil_w_valid_o  = w_valid_q;
  assign axil_b_ready_o  = b_ready_q;
  assign axil_ar_addr_o  = addr_q;
  assign axil_ar_prot_o  = 3'b000;
  assign axil_ar_valid_o = ar_valid_q;
  assign axil_r_ready_o  = r_ready_q;

endmodule

// File: tb/tb_axil_cmd_mgr.sv
// Testbench for axil_cmd_mgr: vector table, hand-written corner sequences and
// randomized transactions against a memory-backed subordinate with
// programmable per-channel wait states.
module tb_axil_cmd_mgr;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_d = 1'b1;

  logic          cmd_valid, cmd_ready_o, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid_o, rsp_ready, rsp_write_o;
  logic [DW-1:0] rsp_rdata_o;
  logic [1:0]    rsp_resp_o;
  logic [CW-1:0] rsp_cycles_o;
  logic [AW-1:0] aw_addr_o, ar_addr_o;
  logic [2:0]    aw_prot_o, ar_prot_o;
  logic          aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o;
  logic          aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic [DW-1:0] w_data_o, r_data;
  logic [SW-1:0] w_strb_o;
  logic [1:0]    b_resp, r_resp;

  always #5 clk = ~clk;

  axil_cmd_mgr #(.AXIL_ADDR_WIDTH(AW), .AXIL_DATA_WIDTH(DW), .LAT_CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o), .rsp_cycles_o(rsp_cycles_o),
    .axil_aw_addr_o(aw_addr_o), .axil_aw_prot_o(aw_prot_o), .axil_aw_valid_o(aw_valid_o),
    .axil_aw_ready_i(aw_ready),
    .axil_w_data_o(w_data_o), .axil_w_strb_o(w_strb_o), .axil_w_valid_o(w_valid_o),
    .axil_w_ready_i(w_ready),
    .axil_b_resp_i(b_resp), .axil_b_valid_i(b_valid), .axil_b_ready_o(b_ready_o),
    .axil_ar_addr_o(ar_addr_o), .axil_ar_prot_o(ar_prot_o), .axil_ar_valid_o(ar_valid_o),
    .axil_ar_ready_i(ar_ready),
    .axil_r_data_i(r_data), .axil_r_resp_i(r_resp), .axil_r_valid_i(r_valid),
    .axil_r_ready_o(r_ready_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  resp;
    int          hold;
    bit          spur;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic [15:0] exp_cyc;
  } vec_t;

  // ---------------- subordinate model ----------------
  int          cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0;
  logic [1:0]  cfg_resp = 2'b00;
  bit          cfg_spur = 1'b0;
  logic [31:0] smem    [256];
  logic [31:0] ref_mem [256];
  int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;
  bit          have_aw = 0, have_w = 0, mon_ok = 0;
  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [31:0] p_awa = '0, p_ara = '0, p_wd = '0;
  logic [3:0]  p_ws = '0;

  always @(posedge clk) rst_d <= rst;

  // Protocol monitor followed by the subordinate; readies/valids are set here for the next edge.
  always @(negedge clk) begin
    if (rst_d) begin
      aw_ready = 0; w_ready = 0; b_valid = 0; ar_ready = 0; r_valid = 0;
      b_resp = 0; r_resp = 0; r_data = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
      have_aw = 0; have_w = 0; mon_ok = 0;
    end else begin
      if (mon_ok) begin
        if (p_awv && !p_awr) check("aw_hold", {aw_valid_o, aw_addr_o}, {1'b1, p_awa});
        if (p_wv && !p_wr)   check("w_hold", {w_valid_o, w_strb_o, w_data_o}, {1'b1, p_ws, p_wd});
        if (p_arv && !p_arr) check("ar_hold", {ar_valid_o, ar_addr_o}, {1'b1, p_ara});
        if (p_awv && p_awr)  check("aw_drop", aw_valid_o, 1'b0);
        if (p_wv && p_wr)    check("w_drop", w_valid_o, 1'b0);
        if (p_arv && p_arr)  check("ar_drop", ar_valid_o, 1'b0);
      end
      if (aw_valid_o || ar_valid_o) check("prot", {aw_prot_o, ar_prot_o}, 6'd0);
      if (rsp_valid_o)
        check("rsp_exclusive", {aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o, cmd_ready_o}, 6'd0);

      aw_ready = 0;
      if (aw_valid_o) begin
        if (aw_wait == cfg_aw) begin
          aw_ready = 1; aw_wait = 0; cap_awaddr = aw_addr_o; have_aw = 1; n_aw++;
        end else aw_wait++;
      end
      w_ready = 0;
      if (w_valid_o) begin
        if (w_wait == cfg_w) begin
          w_ready = 1; w_wait = 0; cap_wdata = w_data_o; cap_wstrb = w_strb_o; have_w = 1; n_w++;
        end else w_wait++;
      end
      if (have_aw && have_w) begin
        for (int b = 0; b < 4; b++)
          if (cap_wstrb[b]) smem[cap_awaddr[9:2]][8*b +: 8] = cap_wdata[8*b +: 8];
        have_aw = 0; have_w = 0;
      end
      b_valid = 0; b_resp = 0;
      if (b_ready_o) begin
        if (b_wait == cfg_b) begin
          b_valid = 1; b_resp = cfg_resp; b_wait = 0; n_b++;
        end else b_wait++;
      end else if (cfg_spur) begin
        b_valid = 1; b_resp = ~cfg_resp;
      end
      ar_ready = 0;
      if (ar_valid_o) begin
        if (ar_wait == cfg_ar) begin
          ar_ready = 1; ar_wait = 0; cap_araddr = ar_addr_o; n_ar++;
        end else ar_wait++;
      end
      r_valid = 0; r_resp = 0; r_data = 0;
      if (r_ready_o) begin
        if (r_wait == cfg_r) begin
          r_valid = 1; r_resp = cfg_resp; r_data = smem[cap_araddr[9:2]]; r_wait = 0; n_r++;
        end else r_wait++;
      end else if (cfg_spur) begin
        r_valid = 1; r_resp = ~cfg_resp; r_data = $urandom;
      end

      p_awv = aw_valid_o; p_awr = aw_ready; p_awa = aw_addr_o;
      p_wv = w_valid_o;   p_wr = w_ready;   p_wd = w_data_o; p_ws = w_strb_o;
      p_arv = ar_valid_o; p_arr = ar_ready; p_ara = ar_addr_o;
      mon_ok = 1;
    end
  end

  // ---------------- reference model ----------------
  // Active cycles: the address/data phase lasts until its slowest channel completes,
  // then the response phase lasts until B/R arrives; each phase is (waits + 1) cycles.
  function automatic int model_cycles(input vec_t v);
    if (v.write) return ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + 1 + v.b_d + 1;
    return v.ar_d + 1 + v.r_d + 1;
  endfunction

  function automatic logic [15:0] sat16(input int c);
    return (c > 65535) ? 16'hFFFF : 16'(c);
  endfunction

  function automatic void ref_write(input vec_t v);
    for (int b = 0; b < 4; b++)
      if (v.wstrb[b]) ref_mem[v.addr[9:2]][8*b +: 8] = v.wdata[8*b +: 8];
  endfunction

  function automatic vec_t mk(input bit w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int awd, input int wd, input int bd,
                              input int ard, input int rd, input logic [1:0] rs, input int hold,
                              input logic [31:0] er, input logic [1:0] ers, input logic [15:0] ec);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.wstrb = s;
    v.aw_d = awd; v.w_d = wd; v.b_d = bd; v.ar_d = ard; v.r_d = rd;
    v.resp = rs; v.hold = hold; v.spur = 1'b0;
    v.exp_rdata = er; v.exp_resp = ers; v.exp_cyc = ec;
    return v;
  endfunction

  // Runs one command starting at a negedge; returns at the negedge after the rsp handshake.
  task automatic run_txn(input string tag, input vec_t v, input bit keep, input vec_t nxt,
                         input int limit, output int acc_wait);
    int n, lat, aw0, w0, b0, ar0, r0;
    bit stable;
    logic [31:0] s_rd; logic [1:0] s_rs; logic [15:0] s_cy; logic s_wr;
    aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
    cfg_aw = v.aw_d; cfg_w = v.w_d; cfg_b = v.b_d; cfg_ar = v.ar_d; cfg_r = v.r_d;
    cfg_resp = v.resp; cfg_spur = v.spur;
    cmd_valid = 1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    n = 0;
    while (!cmd_ready_o && n < 20) begin @(negedge clk); n++; end
    acc_wait = n;
    check({tag, "_accept"}, cmd_ready_o, 1'b1);
    if (!cmd_ready_o) begin cmd_valid = 0; return; end
    @(negedge clk);
    if (keep) begin
      cmd_write = nxt.write; cmd_addr = nxt.addr; cmd_wdata = nxt.wdata; cmd_wstrb = nxt.wstrb;
    end else cmd_valid = 0;
    lat = 1;
    while (!rsp_valid_o && lat < limit) begin @(negedge clk); lat++; end
    check({tag, "_rsp_valid"}, rsp_valid_o, 1'b1);
    if (!rsp_valid_o) return;
    check({tag, "_latency"}, lat, model_cycles(v) + 1);
    check({tag, "_write"}, rsp_write_o, v.write);
    check({tag, "_rdata"}, rsp_rdata_o, v.exp_rdata);
    check({tag, "_resp"}, rsp_resp_o, v.exp_resp);
    check({tag, "_cycles"}, rsp_cycles_o, v.exp_cyc);
    s_rd = rsp_rdata_o; s_rs = rsp_resp_o; s_cy = rsp_cycles_o; s_wr = rsp_write_o;
    stable = 1;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (!(rsp_valid_o && rsp_rdata_o == s_rd && rsp_resp_o == s_rs && rsp_cycles_o == s_cy &&
            rsp_write_o == s_wr && !cmd_ready_o && !aw_valid_o && !w_valid_o && !ar_valid_o))
        stable = 0;
    end
    if (v.hold > 0) check({tag, "_rsp_hold"}, stable, 1'b1);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check({tag, "_rsp_drop"}, rsp_valid_o, 1'b0);
    check({tag, "_ready_again"}, cmd_ready_o, 1'b1);
    check({tag, "_beats"}, {8'(n_aw - aw0), 8'(n_w - w0), 8'(n_b - b0), 8'(n_ar - ar0), 8'(n_r - r0)},
          v.write ? 40'h01_01_01_00_00 : 40'h00_00_00_01_01);
    if (v.write) check({tag, "_aw_w_payload"}, {cap_awaddr, cap_wdata}, {v.addr, v.wdata});
    else         check({tag, "_ar_payload"}, cap_araddr, v.addr);
  endtask

  vec_t tbl [9];
  vec_t va, vb, vr;

  initial begin
    int acc, n;
    bit seen;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
    for (int i = 0; i < 256; i++) begin
      smem[i] = 32'(i) * 32'h0101_0101;
      ref_mem[i] = 32'(i) * 32'h0101_0101;
    end
    //              w  addr        wdata        strb aw w  b  ar r  resp hold exp_rdata    rsp  cyc
    tbl[0] = mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'd0, 0, 32'h0,        2'd0, 16'd2);
    tbl[1] = mk(0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'd0, 1, 32'hDEADBEEF, 2'd0, 16'd2);
    tbl[2] = mk(1, 32'h08, 32'h12345678, 4'hF, 3, 0, 0, 0, 0, 2'd0, 0, 32'h0,        2'd0, 16'd5);
    tbl[3] = mk(0, 32'h08, 32'h0,        4'h0, 0, 0, 0, 0, 5, 2'd2, 0, 32'h12345678, 2'd2, 16'd7);
    tbl[4] = mk(1, 32'h10, 32'h11223344, 4'h5, 1, 1, 2, 0, 0, 2'd3, 2, 32'h0,        2'd3, 16'd5);
    tbl[5] = mk(0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 2, 0, 2'd1, 0, 32'hDE22BE44, 2'd1, 16'd4);
    tbl[6] = mk(1, 32'h0C, 32'hAABBCCDD, 4'hC, 0, 2, 1, 0, 0, 2'd2, 0, 32'h0,        2'd2, 16'd5);
    tbl[7] = mk(0, 32'h0C, 32'h0,        4'h0, 0, 0, 0, 1, 1, 2'd0, 0, 32'hAABB0303, 2'd0, 16'd4);
    tbl[8] = mk(0, 32'h40, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'd0, 0, 32'h10101010, 2'd0, 16'd2);

    // reset state
    repeat (3) @(negedge clk);
    check("reset_ctrl", {cmd_ready_o, rsp_valid_o, rsp_write_o, aw_valid_o, w_valid_o,
                         b_ready_o, ar_valid_o, r_ready_o}, 8'd0);
    check("reset_rsp", {rsp_rdata_o, rsp_resp_o, rsp_cycles_o}, 50'd0);
    check("reset_axil", {aw_addr_o, w_data_o}, 64'd0);
    check("reset_axil2", {ar_addr_o, w_strb_o, aw_prot_o, ar_prot_o}, 42'd0);
    rst = 0;
    @(negedge clk);
    check("ready_after_reset", cmd_ready_o, 1'b1);

    // vector table
    for (int i = 0; i < 9; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i], 1'b0, tbl[i], 100, acc);
      if (tbl[i].write) ref_write(tbl[i]);
    end

    // response back-pressure with the next command already waiting
    va = mk(1, 32'h30, 32'h5A5A5A5A, 4'hF, 0, 0, 0, 0, 0, 2'd0, 10, 32'h0, 2'd0, 16'd2);
    vb = mk(0, 32'h30, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd0, 0, 32'h5A5A5A5A, 2'd0, 16'd2);
    run_txn("held_wr", va, 1'b1, vb, 100, acc);
    ref_write(va);
    run_txn("held_rd", vb, 1'b0, vb, 100, acc);
    check("held_rd_immediate_accept", acc, 0);

    // reset while waiting for R
    cfg_ar = 0; cfg_r = 1000; cfg_spur = 0;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20;
    n = 0;
    while (!cmd_ready_o && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (!r_ready_o && n < 20) begin @(negedge clk); n++; end
    check("reached_rd_r", r_ready_o, 1'b1);
    rst = 1;
    @(negedge clk);
    check("rst_mid_ctrl", {ar_valid_o, r_ready_o, aw_valid_o, w_valid_o, b_ready_o,
                           rsp_valid_o, cmd_ready_o}, 7'd0);
    check("rst_mid_cycles", rsp_cycles_o, 16'd0);
    rst = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid_o) seen = 1;
    end
    check("no_rsp_after_rst", seen, 1'b0);
    check("idle_after_rst", cmd_ready_o, 1'b1);

    // randomized transactions checked against the memory/latency model
    for (int i = 0; i < 40; i++) begin
      vr.write = 1'($urandom_range(0, 1));
      vr.addr  = {22'd0, 4'($urandom_range(0, 15)), 6'd0};
      vr.wdata = $urandom;
      vr.wstrb = 4'($urandom_range(0, 15));
      vr.aw_d = $urandom_range(0, 4); vr.w_d = $urandom_range(0, 4); vr.b_d = $urandom_range(0, 4);
      vr.ar_d = $urandom_range(0, 4); vr.r_d = $urandom_range(0, 4);
      vr.resp = 2'($urandom_range(0, 3));
      vr.hold = $urandom_range(0, 3);
      vr.spur = 1'($urandom_range(0, 1));
      vr.exp_rdata = vr.write ? 32'h0 : ref_mem[vr.addr[9:2]];
      vr.exp_resp  = vr.resp;
      vr.exp_cyc   = sat16(model_cycles(vr));
      run_txn($sformatf("rnd%0d", i), vr, 1'b0, vr, 100, acc);
      if (vr.write) ref_write(vr);
    end

    // latency counter saturation with a long B stall
    va = mk(1, 32'h24, 32'h0BADF00D, 4'hF, 0, 0, 70000, 0, 0, 2'd0, 0, 32'h0, 2'd0, 16'hFFFF);
    run_txn("saturate", va, 1'b0, va, 80000, acc);
    ref_write(va);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
